// File: rtl/mips_defs.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// mips_defs : opcode, funct, FSM state and ALU-operation constants
// Rev 1.0
// ---------------------------------------------------------------------------
package mips_defs;

  typedef enum logic [2:0] {
    ST_IF  = 3'd0,
    ST_ID  = 3'd1,
    ST_EX  = 3'd2,
    ST_MEM = 3'd3,
    ST_WB  = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  function automatic logic [31:0] sign_ext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// alu_decoder : combinational opcode/funct to ALU-operation decode
// Rev 1.0
// ---------------------------------------------------------------------------
module alu_decoder
  import mips_defs::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       funct_ok
);

  always_comb begin
    alu_op   = ALU_ADD;
    funct_ok = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          // Unknown funct still computes an ADD but must never reach the register file
          default: funct_ok = 1'b0;
        endcase
      end
      OP_BEQ:  alu_op = ALU_SUB;
      default: alu_op = ALU_ADD;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// multicycle_ctrl : five-state multicycle MIPS-subset controller and datapath regs
// Rev 1.0
// ---------------------------------------------------------------------------
module multicycle_ctrl
  import mips_defs::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock_in,
  input  logic        reset,
  input  logic [31:0] instr_in,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic [31:0] mem_rdata,
  output logic [31:0] pc,
  output logic [31:0] ir,
  output logic [4:0]  readReg1,
  output logic [4:0]  readReg2,
  output logic        regWrite,
  output logic [4:0]  writeReg,
  output logic [31:0] writeData,
  output logic [2:0]  alu_op,
  output logic        alu_src_imm,
  output logic [31:0] imm_ext,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        memRead,
  output logic        memWrite,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  state
);

  state_t      cur_state;
  state_t      next_state;
  logic [31:0] a_reg;
  logic [31:0] b_reg;
  logic [31:0] alu_out;
  logic [31:0] mdr;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        funct_ok;
  logic        reg_write_raw;
  logic        mem_read_raw;
  logic        mem_write_raw;
  logic [31:0] jump_target;
  logic [31:0] branch_target;

  assign opcode   = ir[31:26];
  assign funct    = ir[5:0];
  assign readReg1 = ir[25:21];
  assign readReg2 = ir[20:16];
  assign imm_ext  = sign_ext16(ir[15:0]);
  assign state    = cur_state;

  // pc already holds the sequential address here, having advanced during IF
  assign jump_target   = {pc[31:28], ir[25:0], 2'b00};
  assign branch_target = pc + {imm_ext[29:0], 2'b00};

  alu_decoder u_alu_decoder (
    .opcode   (opcode),
    .funct    (funct),
    .alu_op   (alu_op),
    .funct_ok (funct_ok)
  );

  always_comb begin
    next_state    = ST_IF;
    reg_write_raw = 1'b0;
    mem_read_raw  = 1'b0;
    mem_write_raw = 1'b0;
    alu_src_imm   = 1'b0;
    case (cur_state)
      ST_IF: next_state = ST_ID;
      ST_ID: begin
        if (opcode == OP_RTYPE || opcode == OP_LW || opcode == OP_SW || opcode == OP_BEQ)
          next_state = ST_EX;
      end
      ST_EX: begin
        if (opcode == OP_LW || opcode == OP_SW) begin
          alu_src_imm = 1'b1;
          next_state  = ST_MEM;
        end else if (opcode == OP_RTYPE) begin
          next_state = ST_WB;
        end
      end
      ST_MEM: begin
        if (opcode == OP_LW) begin
          mem_read_raw = 1'b1;
          next_state   = ST_WB;
        end else if (opcode == OP_SW) begin
          mem_write_raw = 1'b1;
        end
      end
      ST_WB: reg_write_raw = (opcode == OP_RTYPE && funct_ok) || (opcode == OP_LW);
      default: next_state = ST_IF;
    endcase
  end

  assign writeReg  = (opcode == OP_LW) ? ir[20:16] : ir[15:11];
  assign writeData = (opcode == OP_LW) ? mdr : alu_out;
  assign regWrite  = reg_write_raw & ~reset & (writeReg != 5'd0);
  assign memRead   = mem_read_raw & ~reset;
  assign memWrite  = mem_write_raw & ~reset;

  assign alu_a     = a_reg;
  assign alu_b     = alu_src_imm ? imm_ext : b_reg;
  assign mem_addr  = alu_out;
  assign mem_wdata = b_reg;

  always_ff @(posedge clock_in) begin
    if (reset) begin
      cur_state <= ST_IF;
      pc        <= RESET_PC;
      ir        <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      alu_out   <= '0;
      mdr       <= '0;
    end else begin
      cur_state <= next_state;
      case (cur_state)
        ST_IF: begin
          ir <= instr_in;
          pc <= pc + 32'd4;
        end
        ST_ID: begin
          a_reg <= rf_rdata1;
          b_reg <= rf_rdata2;
          if (opcode == OP_J) pc <= jump_target;
        end
        ST_EX: begin
          alu_out <= alu_result;
          if (opcode == OP_BEQ && alu_zero) pc <= branch_target;
        end
        ST_MEM: if (opcode == OP_LW) mdr <= mem_rdata;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl : vector table, corner sequences and random instructions
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

  logic        clock_in = 1'b0;
  logic        reset;
  logic [31:0] instr_in, rf_rdata1, rf_rdata2, alu_result, mem_rdata;
  logic        alu_zero;
  logic [31:0] pc, ir, writeData, imm_ext, alu_a, alu_b, mem_addr, mem_wdata;
  logic [4:0]  readReg1, readReg2, writeReg;
  logic [2:0]  alu_op, state;
  logic        regWrite, alu_src_imm, memRead, memWrite;

  int total = 0;
  int bad   = 0;

  multicycle_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clock_in(clock_in), .reset(reset), .instr_in(instr_in),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .alu_result(alu_result),
    .alu_zero(alu_zero), .mem_rdata(mem_rdata), .pc(pc), .ir(ir),
    .readReg1(readReg1), .readReg2(readReg2), .regWrite(regWrite),
    .writeReg(writeReg), .writeData(writeData), .alu_op(alu_op),
    .alu_src_imm(alu_src_imm), .imm_ext(imm_ext), .alu_a(alu_a), .alu_b(alu_b),
    .memRead(memRead), .memWrite(memWrite), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .state(state)
  );

  always #5 clock_in = ~clock_in;

  typedef struct {
    int          cycles;
    bit          rw;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    bit          mw;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    bit          mr;
    logic [31:0] pc;
    bit          has_ex;
    logic [2:0]  aluop;
    logic [31:0] alua;
    logic [31:0] alub;
  } exp_t;

  typedef struct {
    logic [31:0] ins, rd1, rd2, ares, mrd;
    logic        z;
    exp_t        e;
  } vec_t;

  vec_t vecs[$];
  logic [31:0] model_pc;

  // observations of one instruction, IF through the following IF
  int          o_cycles, o_rw, o_mw, o_mr;
  logic [4:0]  o_wreg, o_rr1, o_rr2;
  logic [31:0] o_wdata, o_maddr, o_mwdata, o_ir, o_alua, o_alub, o_imm;
  logic [2:0]  o_aluop, o_start;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] sext(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  // Transaction-level reference: what one instruction does to pc, the register file and memory
  function automatic exp_t model(input logic [31:0] ins, rd1, rd2, ares, input logic z,
                                 input logic [31:0] mrd, input logic [31:0] cur_pc);
    exp_t        e;
    logic [31:0] seq;
    seq      = cur_pc + 32'd4;
    e        = '{default: '0};
    e.pc     = seq;
    e.cycles = 2;
    e.aluop  = 3'b010;
    e.alua   = rd1;
    case (ins[31:26])
      6'h00: begin
        e.cycles = 4; e.has_ex = 1; e.alub = rd2;
        e.rw = (ins[15:11] != 0);
        case (ins[5:0])
          6'h20: e.aluop = 3'b010;
          6'h22: e.aluop = 3'b110;
          6'h24: e.aluop = 3'b000;
          6'h25: e.aluop = 3'b001;
          6'h2a: e.aluop = 3'b111;
          default: e.rw = 0;
        endcase
        e.wreg = ins[15:11]; e.wdata = ares;
      end
      6'h23: begin
        e.cycles = 5; e.has_ex = 1; e.alub = sext(ins[15:0]); e.mr = 1;
        e.rw = (ins[20:16] != 0); e.wreg = ins[20:16]; e.wdata = mrd;
      end
      6'h2b: begin
        e.cycles = 4; e.has_ex = 1; e.alub = sext(ins[15:0]);
        e.mw = 1; e.maddr = ares; e.mwdata = rd2;
      end
      6'h04: begin
        e.cycles = 3; e.has_ex = 1; e.alub = rd2; e.aluop = 3'b110;
        if (z) e.pc = seq + sext(ins[15:0]) * 4;
      end
      6'h02: e.pc = {seq[31:28], ins[25:0], 2'b00};
      default: ;
    endcase
    return e;
  endfunction

  task automatic execute(input logic [31:0] ins, rd1, rd2, ares, input logic z, input logic [31:0] mrd);
    instr_in = ins; rf_rdata1 = rd1; rf_rdata2 = rd2; alu_result = ares; alu_zero = z; mem_rdata = mrd;
    o_cycles = 0; o_rw = 0; o_mw = 0; o_mr = 0;
    o_wreg = '0; o_rr1 = '0; o_rr2 = '0; o_wdata = '0; o_maddr = '0; o_mwdata = '0;
    o_ir = '0; o_alua = '0; o_alub = '0; o_imm = '0; o_aluop = '0;
    o_start = state;
    do begin
      if (regWrite) begin o_rw++; o_wreg = writeReg; o_wdata = writeData; end
      if (memWrite) begin o_mw++; o_maddr = mem_addr; o_mwdata = mem_wdata; end
      if (memRead) o_mr++;
      if (state == 3'd1) begin o_ir = ir; o_rr1 = readReg1; o_rr2 = readReg2; end
      if (state == 3'd2) begin o_aluop = alu_op; o_alua = alu_a; o_alub = alu_b; o_imm = imm_ext; end
      @(negedge clock_in);
      o_cycles++;
    end while (state != 3'd0 && o_cycles < 10);
  endtask

  task automatic compare(input string tag, input logic [31:0] ins, input exp_t e);
    chk({tag, " start_state"}, o_start, 0);
    chk({tag, " cycles"}, o_cycles, e.cycles);
    chk({tag, " pc"}, pc, e.pc);
    chk({tag, " regWrite_pulses"}, o_rw, e.rw);
    if (e.rw) begin
      chk({tag, " writeReg"}, o_wreg, e.wreg);
      chk({tag, " writeData"}, o_wdata, e.wdata);
    end
    chk({tag, " memWrite_pulses"}, o_mw, e.mw);
    if (e.mw) begin
      chk({tag, " mem_addr"}, o_maddr, e.maddr);
      chk({tag, " mem_wdata"}, o_mwdata, e.mwdata);
    end
    chk({tag, " memRead_cycles"}, o_mr, e.mr);
    chk({tag, " ir"}, o_ir, ins);
    chk({tag, " readReg1"}, o_rr1, ins[25:21]);
    chk({tag, " readReg2"}, o_rr2, ins[20:16]);
    if (e.has_ex) begin
      chk({tag, " alu_op"}, o_aluop, e.aluop);
      chk({tag, " alu_a"}, o_alua, e.alua);
      chk({tag, " alu_b"}, o_alub, e.alub);
      chk({tag, " imm_ext"}, o_imm, sext(ins[15:0]));
    end
  endtask

  task automatic run_model(input string tag, input logic [31:0] ins, rd1, rd2, ares,
                           input logic z, input logic [31:0] mrd);
    exp_t e;
    e = model(ins, rd1, rd2, ares, z, mrd, model_pc);
    execute(ins, rd1, rd2, ares, z, mrd);
    compare(tag, ins, e);
    model_pc = e.pc;
  endtask

  task automatic add_vec(input logic [31:0] ins, rd1, rd2, ares, input logic z, input logic [31:0] mrd,
                         input int cyc, input bit rw, input logic [4:0] wreg, input logic [31:0] wdata,
                         input bit mw, input logic [31:0] maddr, mwdata, input bit mr,
                         input logic [31:0] npc, input bit has_ex, input logic [2:0] aop,
                         input logic [31:0] alub);
    vec_t v;
    v.ins = ins; v.rd1 = rd1; v.rd2 = rd2; v.ares = ares; v.z = z; v.mrd = mrd;
    v.e.cycles = cyc; v.e.rw = rw; v.e.wreg = wreg; v.e.wdata = wdata;
    v.e.mw = mw; v.e.maddr = maddr; v.e.mwdata = mwdata; v.e.mr = mr; v.e.pc = npc;
    v.e.has_ex = has_ex; v.e.aluop = aop; v.e.alua = rd1; v.e.alub = alub;
    vecs.push_back(v);
  endtask

  task automatic step_to(input string tag, input logic [2:0] st);
    int n = 0;
    while (state != st && n < 10) begin
      @(negedge clock_in);
      n++;
    end
    chk({tag, " reach_state"}, state, st);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock_in);
    @(negedge clock_in);
    reset = 1'b0;
    #1;
    model_pc = 32'h0;
  endtask

  initial begin
    instr_in = '0; rf_rdata1 = '0; rf_rdata2 = '0; alu_result = '0; alu_zero = 1'b0; mem_rdata = '0;
    reset = 1'b1;
    @(negedge clock_in);
    @(negedge clock_in);
    chk("rst state", state, 0);
    chk("rst pc", pc, 0);
    chk("rst ir", ir, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst strobes", {regWrite, memRead, memWrite}, 0);
    reset = 1'b0;
    #1;
    chk("post_rst state", state, 0);
    chk("post_rst pc", pc, 0);
    chk("post_rst strobes", {regWrite, memRead, memWrite}, 0);
    model_pc = 32'h0;

    // instr, rd1, rd2, alu_result, zero, mem_rdata | cycles, rw, wreg, wdata, mw, maddr, mwdata, mr, pc, ex, alu_op, alu_b
    add_vec(32'h00221820, 2, 3, 5, 0, 0,                     4, 1, 3, 5, 0, 0, 0, 0, 32'h04, 1, 3'b010, 3);
    add_vec(32'h8C220008, 32'h30, 32'h777, 32'h38, 0, 32'hDEADBEEF,
                                                             5, 1, 2, 32'hDEADBEEF, 0, 0, 0, 1, 32'h08, 1, 3'b010, 8);
    add_vec(32'hAC220004, 32'h3C, 32'h12345678, 32'h40, 0, 0,
                                                             4, 0, 0, 0, 1, 32'h40, 32'h12345678, 0, 32'h0C, 1, 3'b010, 4);
    add_vec(32'h00220020, 1, 2, 3, 0, 0,                     4, 0, 0, 0, 0, 0, 0, 0, 32'h10, 1, 3'b010, 2);
    add_vec(32'h1000FFFF, 7, 7, 0, 1, 0,                     3, 0, 0, 0, 0, 0, 0, 0, 32'h10, 1, 3'b110, 7);
    add_vec(32'h1000FFFF, 7, 8, 1, 0, 0,                     3, 0, 0, 0, 0, 0, 0, 0, 32'h14, 1, 3'b110, 8);
    add_vec(32'h08000040, 0, 0, 0, 0, 0,                     2, 0, 0, 0, 0, 0, 0, 0, 32'h100, 0, 3'b010, 0);
    add_vec(32'h3C010001, 0, 0, 0, 0, 0,                     2, 0, 0, 0, 0, 0, 0, 0, 32'h104, 0, 3'b010, 0);
    add_vec(32'h00221821, 4, 5, 9, 0, 0,                     4, 0, 0, 0, 0, 0, 0, 0, 32'h108, 1, 3'b010, 5);
    add_vec(32'h00221822, 9, 4, 5, 0, 0,                     4, 1, 3, 5, 0, 0, 0, 0, 32'h10C, 1, 3'b110, 4);
    add_vec(32'h0022182A, 1, 2, 1, 0, 0,                     4, 1, 3, 1, 0, 0, 0, 0, 32'h110, 1, 3'b111, 2);
    add_vec(32'h00221824, 6, 3, 2, 0, 0,                     4, 1, 3, 2, 0, 0, 0, 0, 32'h114, 1, 3'b000, 3);
    add_vec(32'h00221825, 6, 3, 7, 0, 0,                     4, 1, 3, 7, 0, 0, 0, 0, 32'h118, 1, 3'b001, 3);

    foreach (vecs[i]) begin
      execute(vecs[i].ins, vecs[i].rd1, vecs[i].rd2, vecs[i].ares, vecs[i].z, vecs[i].mrd);
      compare($sformatf("vec%0d", i), vecs[i].ins, vecs[i].e);
      model_pc = vecs[i].e.pc;
    end

    // pc wrap: jump to 0, branch back by two words, then step across the top of memory
    run_model("wrap_j", 32'h08000000, 0, 0, 0, 0, 0);
    run_model("wrap_beq", 32'h1000FFFE, 1, 1, 0, 1, 0);
    chk("wrap pc_top", pc, 32'hFFFF_FFFC);
    run_model("wrap_add", 32'h00221820, 1, 1, 2, 0, 0);
    chk("wrap pc_zero", pc, 32'h0);

    // reset during MEM of sw aborts the store
    do_reset();
    instr_in = 32'hAC220004; alu_result = 32'h40; rf_rdata2 = 32'h55;
    step_to("rst_sw", 3'd3);
    chk("rst_sw memWrite_before", memWrite, 1);
    reset = 1'b1;
    #1;
    chk("rst_sw memWrite_forced", memWrite, 0);
    @(negedge clock_in);
    chk("rst_sw state", state, 0);
    chk("rst_sw pc", pc, 0);
    chk("rst_sw ir", ir, 0);
    reset = 1'b0;
    #1;
    chk("rst_sw post strobes", {regWrite, memRead, memWrite}, 0);

    // reset during WB of lw suppresses the register write
    instr_in = 32'h8C220008; mem_rdata = 32'h1234;
    step_to("rst_lw", 3'd4);
    chk("rst_lw regWrite_before", regWrite, 1);
    reset = 1'b1;
    #1;
    chk("rst_lw regWrite_forced", regWrite, 0);
    @(negedge clock_in);
    chk("rst_lw state", state, 0);
    reset = 1'b0;
    #1;
    model_pc = 32'h0;

    for (int n = 0; n < 150; n++) begin
      logic [31:0] ins;
      logic [5:0]  fl [5];
      int          kind;
      fl   = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
      ins  = $urandom;
      kind = $urandom_range(0, 6);
      case (kind)
        0: begin ins[31:26] = 6'h00; ins[5:0] = fl[$urandom_range(0, 4)]; end
        1: ins[31:26] = 6'h00;
        2: ins[31:26] = 6'h23;
        3: ins[31:26] = 6'h2b;
        4: ins[31:26] = 6'h04;
        5: ins[31:26] = 6'h02;
        default: ins[31:26] = 6'($urandom_range(0, 63));
      endcase
      if ($urandom_range(0, 7) == 0) ins[15:11] = 5'd0;
      if ($urandom_range(0, 7) == 0) ins[20:16] = 5'd0;
      run_model($sformatf("rnd%0d", n), ins, $urandom, $urandom, $urandom,
                1'($urandom_range(0, 1)), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
